// File: rtl/aib_axi_link_ctrl_pkg.sv
// Shared types for the AIB link bring-up controller: FSM state encoding and
// the widths of the exported state and retry counter.
package aib_link_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RSTN  = 3'd1,
    ST_LOCK  = 3'd2,
    ST_MAC   = 3'd3,
    ST_UP    = 3'd4,
    ST_RETRY = 3'd5,
    ST_ERR   = 3'd6
  } link_state_e;

endpackage

// File: rtl/aib_axi_link_ctrl_if.sv
// Control/status bundle between SoC logic, the far-side channel status and
// the link controller. The master side drives requests and far-side status.
interface aib_axi_link_ctrl_if
  import aib_link_ctrl_pkg::*;
#(
  parameter int NBR_CHNLS = 24,
  parameter int TIMEOUT_W = 16
);
  logic                 start;
  logic                 stop;
  logic [NBR_CHNLS-1:0] chnl_en;
  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic [NBR_CHNLS-1:0] ns_adapter_rstn;
  logic [NBR_CHNLS-1:0] ms_tx_dcc_dll_lock_req;
  logic [NBR_CHNLS-1:0] ms_rx_dcc_dll_lock_req;
  logic [NBR_CHNLS-1:0] sl_tx_dcc_dll_lock_req;
  logic [NBR_CHNLS-1:0] sl_rx_dcc_dll_lock_req;
  logic [NBR_CHNLS-1:0] ns_mac_rdy;
  logic [NBR_CHNLS-1:0] ms_tx_transfer_en;
  logic [NBR_CHNLS-1:0] sl_tx_transfer_en;
  logic [NBR_CHNLS-1:0] fs_mac_rdy;
  logic [NBR_CHNLS-1:0] m_rx_align_done;
  logic                 link_up;
  logic                 link_err;
  logic [STATE_W-1:0]   state;
  logic [RETRY_W-1:0]   retry_cnt;

  modport master (
    output start, stop, chnl_en, timeout_cycles,
    output ms_tx_transfer_en, sl_tx_transfer_en, fs_mac_rdy, m_rx_align_done,
    input  ns_adapter_rstn, ms_tx_dcc_dll_lock_req, ms_rx_dcc_dll_lock_req,
    input  sl_tx_dcc_dll_lock_req, sl_rx_dcc_dll_lock_req, ns_mac_rdy,
    input  link_up, link_err, state, retry_cnt
  );

  modport slave (
    input  start, stop, chnl_en, timeout_cycles,
    input  ms_tx_transfer_en, sl_tx_transfer_en, fs_mac_rdy, m_rx_align_done,
    output ns_adapter_rstn, ms_tx_dcc_dll_lock_req, ms_rx_dcc_dll_lock_req,
    output sl_tx_dcc_dll_lock_req, sl_rx_dcc_dll_lock_req, ns_mac_rdy,
    output link_up, link_err, state, retry_cnt
  );
endinterface

// File: rtl/aib_axi_link_ctrl_sync.sv
// Two-flop synchroniser bank for far-side status vectors. Only compiled when
// AIB_LINK_SYNC_EN is defined, since nothing else instantiates it.
`ifdef AIB_LINK_SYNC_EN
module aib_link_sync #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule
`endif

// File: rtl/aib_axi_link_ctrl.sv
// AIB link bring-up/supervision FSM: adapter reset, DCC/DLL lock, MAC ready,
// link monitor and bounded retry. Define AIB_LINK_SYNC_EN to synchronise far-side status.
module aib_axi_link_ctrl
  import aib_link_ctrl_pkg::*;
#(
  parameter int NBR_CHNLS    = 24,
  parameter int ACTIVE_CHNLS = 1,
  parameter int TIMEOUT_W    = 16,
  parameter int RST_HOLD     = 16,
  parameter int RETRY_MAX    = 3
) (
  input logic                clk_wr,
  input logic                rst_wr,
  aib_axi_link_ctrl_if.slave bus
);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  function automatic logic [NBR_CHNLS-1:0] mk_static_mask();
    logic [NBR_CHNLS-1:0] m;
    m = '0;
    for (int i = 0; i < NBR_CHNLS; i++) begin
      if (i < ACTIVE_CHNLS) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NBR_CHNLS-1:0] STATIC_MASK = mk_static_mask();

  logic [NBR_CHNLS-1:0] ms_xfer, sl_xfer, fs_rdy, rx_align;

`ifdef AIB_LINK_SYNC_EN
  aib_link_sync #(.W(NBR_CHNLS)) u_sync_ms_xfer (
    .clk_i(clk_wr), .rst_i(rst_wr), .d_i(bus.ms_tx_transfer_en), .q_o(ms_xfer));
  aib_link_sync #(.W(NBR_CHNLS)) u_sync_sl_xfer (
    .clk_i(clk_wr), .rst_i(rst_wr), .d_i(bus.sl_tx_transfer_en), .q_o(sl_xfer));
  aib_link_sync #(.W(NBR_CHNLS)) u_sync_fs_rdy (
    .clk_i(clk_wr), .rst_i(rst_wr), .d_i(bus.fs_mac_rdy), .q_o(fs_rdy));
  aib_link_sync #(.W(NBR_CHNLS)) u_sync_align (
    .clk_i(clk_wr), .rst_i(rst_wr), .d_i(bus.m_rx_align_done), .q_o(rx_align));
`else
  assign ms_xfer  = bus.ms_tx_transfer_en;
  assign sl_xfer  = bus.sl_tx_transfer_en;
  assign fs_rdy   = bus.fs_mac_rdy;
  assign rx_align = bus.m_rx_align_done;
`endif

  link_state_e          state_q, state_d;
  logic [NBR_CHNLS-1:0] act_q, act_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [NBR_CHNLS-1:0] rstn_q, rstn_d, lock_q, lock_d, mac_q, mac_d;
  logic                 up_q, up_d, err_q, err_d;
  logic                 lock_ok, mac_ok, tmo_hit;

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      retry_q <= '0;
      hold_q  <= '0;
      tmo_q   <= '0;
      rstn_q  <= '0;
      lock_q  <= '0;
      mac_q   <= '0;
      up_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      retry_q <= retry_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      rstn_q  <= rstn_d;
      lock_q  <= lock_d;
      mac_q   <= mac_d;
      up_q    <= up_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    retry_d = retry_q;
    lock_ok = ((ms_xfer & sl_xfer & act_q) == act_q);
    mac_ok  = ((fs_rdy & rx_align & act_q) == act_q);
    tmo_hit = (bus.timeout_cycles != '0) && (tmo_q == bus.timeout_cycles);

    if (bus.stop) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            act_d   = bus.chnl_en & STATIC_MASK;
            retry_d = '0;
            state_d = (act_d == '0) ? ST_ERR : ST_RSTN;
          end
        end
        ST_RSTN:  if (hold_q == HOLD_W'(RST_HOLD)) state_d = ST_LOCK;
        ST_LOCK: begin
          if (tmo_hit)      state_d = ST_RETRY;
          else if (lock_ok) state_d = ST_MAC;
        end
        ST_MAC: begin
          if (tmo_hit)     state_d = ST_RETRY;
          else if (mac_ok) state_d = ST_UP;
        end
        ST_UP:    if (!mac_ok) state_d = ST_RETRY;
        ST_RETRY: begin
          if (retry_q == RETRY_W'(RETRY_MAX)) begin
            state_d = ST_ERR;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_RSTN;
          end
        end
        ST_ERR:   state_d = ST_ERR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Hold and timeout counters restart on every state change.
  always_comb begin
    hold_d = hold_q;
    tmo_d  = tmo_q;
    if (state_d != state_q) begin
      hold_d = '0;
      tmo_d  = '0;
    end else begin
      if (state_q == ST_RSTN) hold_d = hold_q + HOLD_W'(1);
      if (state_q == ST_LOCK || state_q == ST_MAC) tmo_d = tmo_q + TIMEOUT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they switch with the state register.
  always_comb begin
    rstn_d = '0;
    lock_d = '0;
    mac_d  = '0;
    up_d   = (state_d == ST_UP);
    err_d  = (state_d == ST_ERR);
    if (state_d == ST_LOCK || state_d == ST_MAC || state_d == ST_UP) begin
      rstn_d = act_d;
      lock_d = act_d;
    end
    if (state_d == ST_MAC || state_d == ST_UP) mac_d = act_d;
  end

  assign bus.ns_adapter_rstn        = rstn_q;
  assign bus.ms_tx_dcc_dll_lock_req = lock_q;
  assign bus.ms_rx_dcc_dll_lock_req = lock_q;
  assign bus.sl_tx_dcc_dll_lock_req = lock_q;
  assign bus.sl_rx_dcc_dll_lock_req = lock_q;
  assign bus.ns_mac_rdy             = mac_q;
  assign bus.link_up                = up_q;
  assign bus.link_err               = err_q;
  assign bus.state                  = state_q;
  assign bus.retry_cnt              = retry_q;
endmodule

// File: tb/tb_aib_axi_link_ctrl.sv
// Directed bench for aib_axi_link_ctrl: vector table for the main flow plus
// hand-written timeout, priority, reset and masking sequences.
module tb_aib_axi_link_ctrl;
  logic clk_wr = 1'b0;
  logic rst_wr;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_wr = ~clk_wr;

  aib_axi_link_ctrl_if #(.NBR_CHNLS(24), .TIMEOUT_W(16)) if0 ();
  aib_axi_link_ctrl_if #(.NBR_CHNLS(24), .TIMEOUT_W(16)) if1 ();

  aib_axi_link_ctrl #(.NBR_CHNLS(24), .ACTIVE_CHNLS(1), .TIMEOUT_W(16),
                      .RST_HOLD(16), .RETRY_MAX(3))
    dut0 (.clk_wr(clk_wr), .rst_wr(rst_wr), .bus(if0.slave));

  aib_axi_link_ctrl #(.NBR_CHNLS(24), .ACTIVE_CHNLS(4), .TIMEOUT_W(16),
                      .RST_HOLD(16), .RETRY_MAX(3))
    dut1 (.clk_wr(clk_wr), .rst_wr(rst_wr), .bus(if1.slave));

  typedef struct {
    int          n;
    logic        rst, start, stop;
    logic [23:0] en, ms, sl, fs, al;
    logic [15:0] tmo;
    logic [2:0]  st;
    logic [23:0] rstn, lck, mac;
    logic        up, err;
    logic [3:0]  rc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int n, logic rst, logic start, logic stop,
                              logic [23:0] en, logic [23:0] ms, logic [23:0] sl,
                              logic [23:0] fs, logic [23:0] al, logic [15:0] tmo,
                              logic [2:0] st, logic [23:0] rstn, logic [23:0] lck,
                              logic [23:0] mac, logic up, logic err, logic [3:0] rc);
    vec_t v;
    v.n = n; v.rst = rst; v.start = start; v.stop = stop; v.en = en;
    v.ms = ms; v.sl = sl; v.fs = fs; v.al = al; v.tmo = tmo; v.st = st;
    v.rstn = rstn; v.lck = lck; v.mac = mac; v.up = up; v.err = err; v.rc = rc;
    return v;
  endfunction

  task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk0(string tag, logic [2:0] st, logic [23:0] rstn, logic [23:0] lck,
                      logic [23:0] mac, logic up, logic err, logic [3:0] rc);
    cmp({tag, ".state"}, 32'(if0.state), 32'(st));
    cmp({tag, ".rstn"}, 32'(if0.ns_adapter_rstn), 32'(rstn));
    cmp({tag, ".ms_tx_lock"}, 32'(if0.ms_tx_dcc_dll_lock_req), 32'(lck));
    cmp({tag, ".ms_rx_lock"}, 32'(if0.ms_rx_dcc_dll_lock_req), 32'(lck));
    cmp({tag, ".sl_tx_lock"}, 32'(if0.sl_tx_dcc_dll_lock_req), 32'(lck));
    cmp({tag, ".sl_rx_lock"}, 32'(if0.sl_rx_dcc_dll_lock_req), 32'(lck));
    cmp({tag, ".mac_rdy"}, 32'(if0.ns_mac_rdy), 32'(mac));
    cmp({tag, ".link_up"}, 32'(if0.link_up), 32'(up));
    cmp({tag, ".link_err"}, 32'(if0.link_err), 32'(err));
    cmp({tag, ".retry_cnt"}, 32'(if0.retry_cnt), 32'(rc));
  endtask

  task automatic chk1(string tag, logic [2:0] st, logic [23:0] rstn, logic [23:0] lck,
                      logic [23:0] mac, logic up);
    cmp({tag, ".state"}, 32'(if1.state), 32'(st));
    cmp({tag, ".rstn"}, 32'(if1.ns_adapter_rstn), 32'(rstn));
    cmp({tag, ".ms_tx_lock"}, 32'(if1.ms_tx_dcc_dll_lock_req), 32'(lck));
    cmp({tag, ".sl_rx_lock"}, 32'(if1.sl_rx_dcc_dll_lock_req), 32'(lck));
    cmp({tag, ".mac_rdy"}, 32'(if1.ns_mac_rdy), 32'(mac));
    cmp({tag, ".link_up"}, 32'(if1.link_up), 32'(up));
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk_wr);
  endtask

  initial begin
    rst_wr = 1'b1;
    if0.start = 1'b0; if0.stop = 1'b0; if0.chnl_en = '0; if0.timeout_cycles = '0;
    if0.ms_tx_transfer_en = '0; if0.sl_tx_transfer_en = '0;
    if0.fs_mac_rdy = '0; if0.m_rx_align_done = '0;
    if1.start = 1'b0; if1.stop = 1'b0; if1.chnl_en = '0; if1.timeout_cycles = '0;
    if1.ms_tx_transfer_en = '0; if1.sl_tx_transfer_en = '0;
    if1.fs_mac_rdy = '0; if1.m_rx_align_done = '0;

    //        n  rst st sp  en     ms     sl     fs     al     tmo  st  rstn   lck    mac    up err rc
    vt.push_back(mk(2, 1, 0, 0, 24'h1, 24'h0, 24'h0, 24'h0, 24'h0, 16'd0, 3'd0, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0));
    vt.push_back(mk(1, 0, 1, 0, 24'h1, 24'h0, 24'h0, 24'h0, 24'h0, 16'd0, 3'd1, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0));
    vt.push_back(mk(16, 0, 0, 0, 24'h1, 24'h0, 24'h0, 24'h0, 24'h0, 16'd0, 3'd1, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0));
    vt.push_back(mk(1, 0, 0, 0, 24'h1, 24'h0, 24'h0, 24'h0, 24'h0, 16'd0, 3'd2, 24'h1, 24'h1, 24'h0, 0, 0, 4'd0));
    vt.push_back(mk(4, 0, 0, 0, 24'h1, 24'h0, 24'h0, 24'h0, 24'h0, 16'd0, 3'd2, 24'h1, 24'h1, 24'h0, 0, 0, 4'd0));
    vt.push_back(mk(1, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h0, 24'h0, 16'd0, 3'd3, 24'h1, 24'h1, 24'h1, 0, 0, 4'd0));
    vt.push_back(mk(4, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h0, 24'h0, 16'd0, 3'd3, 24'h1, 24'h1, 24'h1, 0, 0, 4'd0));
    vt.push_back(mk(1, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd4, 24'h1, 24'h1, 24'h1, 1, 0, 4'd0));
    vt.push_back(mk(3, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd4, 24'h1, 24'h1, 24'h1, 1, 0, 4'd0));
    vt.push_back(mk(1, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h0, 16'd0, 3'd5, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0));
    vt.push_back(mk(1, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd1, 24'h0, 24'h0, 24'h0, 0, 0, 4'd1));
    vt.push_back(mk(16, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd1, 24'h0, 24'h0, 24'h0, 0, 0, 4'd1));
    vt.push_back(mk(1, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd2, 24'h1, 24'h1, 24'h0, 0, 0, 4'd1));
    vt.push_back(mk(1, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd3, 24'h1, 24'h1, 24'h1, 0, 0, 4'd1));
    vt.push_back(mk(1, 0, 0, 0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd4, 24'h1, 24'h1, 24'h1, 1, 0, 4'd1));
    vt.push_back(mk(1, 0, 0, 1, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd0, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0));
    vt.push_back(mk(1, 0, 1, 0, 24'h0, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd6, 24'h0, 24'h0, 24'h0, 0, 1, 4'd0));
    vt.push_back(mk(3, 0, 1, 0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd6, 24'h0, 24'h0, 24'h0, 0, 1, 4'd0));
    vt.push_back(mk(1, 0, 0, 1, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1, 16'd0, 3'd0, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0));

    @(negedge clk_wr);
    foreach (vt[i]) begin
      rst_wr = vt[i].rst;
      if0.start = vt[i].start; if0.stop = vt[i].stop; if0.chnl_en = vt[i].en;
      if0.ms_tx_transfer_en = vt[i].ms; if0.sl_tx_transfer_en = vt[i].sl;
      if0.fs_mac_rdy = vt[i].fs; if0.m_rx_align_done = vt[i].al;
      if0.timeout_cycles = vt[i].tmo;
      step(vt[i].n);
      chk0($sformatf("vec%0d", i), vt[i].st, vt[i].rstn, vt[i].lck, vt[i].mac,
           vt[i].up, vt[i].err, vt[i].rc);
    end

    // Timeout retries until the retry budget is exhausted.
    if0.stop = 1'b0; if0.start = 1'b1; if0.chnl_en = 24'h1; if0.timeout_cycles = 16'd8;
    if0.ms_tx_transfer_en = '0; if0.sl_tx_transfer_en = '0;
    if0.fs_mac_rdy = '0; if0.m_rx_align_done = '0;
    step(1);
    if0.start = 1'b0;
    chk0("to.rstn0", 3'd1, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0);
    step(17); chk0("to.lock0", 3'd2, 24'h1, 24'h1, 24'h0, 0, 0, 4'd0);
    step(8);  chk0("to.wait0", 3'd2, 24'h1, 24'h1, 24'h0, 0, 0, 4'd0);
    step(1);  chk0("to.retry0", 3'd5, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0);
    step(1);  chk0("to.back0", 3'd1, 24'h0, 24'h0, 24'h0, 0, 0, 4'd1);
    for (int a = 1; a <= 3; a++) begin
      step(17); chk0($sformatf("to.lock%0d", a), 3'd2, 24'h1, 24'h1, 24'h0, 0, 0, 4'(a));
      step(9);  chk0($sformatf("to.retry%0d", a), 3'd5, 24'h0, 24'h0, 24'h0, 0, 0, 4'(a));
      step(1);
      if (a < 3) chk0($sformatf("to.back%0d", a), 3'd1, 24'h0, 24'h0, 24'h0, 0, 0, 4'(a + 1));
      else       chk0("to.err", 3'd6, 24'h0, 24'h0, 24'h0, 0, 1, 4'd3);
    end
    step(4); chk0("to.sticky", 3'd6, 24'h0, 24'h0, 24'h0, 0, 1, 4'd3);

    // Stop coinciding with timeout wins.
    if0.stop = 1'b1; step(1); chk0("pr.idle", 3'd0, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0);
    if0.stop = 1'b0; if0.start = 1'b1; step(1); if0.start = 1'b0;
    step(17); step(8); chk0("pr.lock", 3'd2, 24'h1, 24'h1, 24'h0, 0, 0, 4'd0);
    if0.stop = 1'b1; step(1); chk0("pr.stop_vs_to", 3'd0, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0);
    if0.stop = 1'b0;

    // Reset in MAC aborts immediately.
    if0.timeout_cycles = 16'd0; if0.ms_tx_transfer_en = 24'h1; if0.sl_tx_transfer_en = 24'h1;
    if0.start = 1'b1; step(1); if0.start = 1'b0;
    step(17); step(1); chk0("rs.mac", 3'd3, 24'h1, 24'h1, 24'h1, 0, 0, 4'd0);
    rst_wr = 1'b1; step(1); chk0("rs.abort", 3'd0, 24'h0, 24'h0, 24'h0, 0, 0, 4'd0);
    rst_wr = 1'b0;

    // Channel masking with four statically active channels.
    if1.chnl_en = 24'hFF; if1.ms_tx_transfer_en = 24'h0F; if1.sl_tx_transfer_en = 24'h0F;
    if1.start = 1'b1; step(1); if1.start = 1'b0;
    chk1("mk.rstn", 3'd1, 24'h0, 24'h0, 24'h0, 0);
    step(17); chk1("mk.lock", 3'd2, 24'h0F, 24'h0F, 24'h0, 0);
    step(1);  chk1("mk.mac", 3'd3, 24'h0F, 24'h0F, 24'h0F, 0);
    if1.fs_mac_rdy = 24'h0F; if1.m_rx_align_done = 24'h0F;
    step(1);  chk1("mk.up", 3'd4, 24'h0F, 24'h0F, 24'h0F, 1);
    if1.m_rx_align_done = 24'h2F;
    step(2);  chk1("mk.hold", 3'd4, 24'h0F, 24'h0F, 24'h0F, 1);
    if1.m_rx_align_done = 24'h07;
    step(1);  chk1("mk.drop", 3'd5, 24'h0, 24'h0, 24'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
